// File: rtl/flash_stream_reader.sv
// Sequential block reader in front of the SPI flash controller: issues one read at a time,
// waits out the fixed controller latency and queues the words in a show-ahead FIFO.
module flash_stream_reader #(
  parameter int ADDR_W     = 22,
  parameter int DATA_W     = 16,
  parameter int READ_LAT   = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [15:0]       word_count,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              flash_cs,
  output logic [ADDR_W-1:0] flash_address,
  input  logic [DATA_W-1:0] flash_dout
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       LAT_INIT = 8'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [15:0]       remaining;
  logic [7:0]        lat_cnt;
  logic              zero_done;
  logic              sample;
  logic              pop;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;

  assign busy          = (state != IDLE);
  assign flash_address = addr;
  assign sample        = (state == WAIT) && (lat_cnt == '0);
  assign data_valid    = (count != '0);
  assign pop           = data_valid && data_ready;
  // Stale RAM contents are hidden while the FIFO is empty, so data_out reads 0 after reset.
  assign data_out      = data_valid ? mem[rd_ptr] : '0;

  // NOTE: every output of this block is given a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    flash_cs  = 1'b0;
    done      = zero_done;
    case (state)
      IDLE: begin
        if (start && (word_count != '0)) state_nxt = ISSUE;
      end
      ISSUE: begin
        // Only one read is in flight, so a free slot now is still free at sample time.
        if (count < DEPTH_C) begin
          flash_cs  = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          if (remaining == 16'd1) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            state_nxt = ISSUE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
      zero_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      zero_done <= (state == IDLE) && start && (word_count == '0);
      if ((state == IDLE) && start && (word_count != '0)) begin
        addr      <= start_addr;
        remaining <= word_count;
      end
      if (flash_cs) begin
        lat_cnt <= LAT_INIT;
      end else if ((state == WAIT) && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
      if (sample) begin
        addr      <= addr + 1'b1;
        remaining <= remaining - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (sample) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({sample, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the pointers and count alone define what is valid.
  always_ff @(posedge clk) begin
    if (sample) mem[wr_ptr] <= flash_dout;
  end

endmodule

// File: tb/tb_flash_stream_reader.sv
// Bench for flash_stream_reader: a latency-accurate flash model feeds a scoreboard queue
// that is popped and compared on every consumer handshake.
module tb_flash_stream_reader;

  localparam int ADDR_W     = 22;
  localparam int DATA_W     = 16;
  localparam int READ_LAT   = 32;
  localparam int FIFO_DEPTH = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [15:0]       word_count;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;
  logic              flash_cs;
  logic [ADDR_W-1:0] flash_address;
  logic [DATA_W-1:0] flash_dout;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  flash_stream_reader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LAT(READ_LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .busy(busy), .done(done), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .flash_cs(flash_cs),
    .flash_address(flash_address), .flash_dout(flash_dout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Flash model, scoreboard and consumer monitor, all sampled on the falling edge.
  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] cs_addr_q[$];
  int                cs_cyc_q[$];
  int                cs_total  = 0;
  int                pop_total = 0;
  int                due       = -1;
  logic [ADDR_W-1:0] pend_addr = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      due        = -1;
      flash_dout = '0;
    end else begin
      if (due >= 0) begin
        checks++;
        if (flash_address !== pend_addr) begin
          failures++;
          $display("FAIL addr_stable cyc=%0d got=%h want=%h", cyc, flash_address, pend_addr);
        end
      end
      if (cyc == due) begin
        flash_dout = pend_addr[15:0];
        due        = -1;
      end else begin
        flash_dout = ~pend_addr[15:0];
      end
      if (flash_cs) begin
        checks++;
        if (due >= 0) begin
          failures++;
          $display("FAIL one_in_flight cyc=%0d second cs before sample", cyc);
        end
        due       = cyc + READ_LAT;
        pend_addr = flash_address;
        exp_q.push_back(flash_address[15:0]);
        cs_addr_q.push_back(flash_address);
        cs_cyc_q.push_back(cyc);
        cs_total++;
      end
      if (data_valid && data_ready) begin
        pop_total++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL pop_unexpected cyc=%0d got=%h want=<none>", cyc, data_out);
        end else begin
          logic [DATA_W-1:0] exp_w;
          exp_w = exp_q.pop_front();
          if (data_out !== exp_w) begin
            failures++;
            $display("FAIL pop_data cyc=%0d got=%h want=%h", cyc, data_out, exp_w);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] a, input logic [15:0] n);
    start      = 1'b1;
    start_addr = a;
    word_count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_cs(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (cs_total >= target) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic clear_log();
    cs_addr_q.delete();
    cs_cyc_q.delete();
  endtask

  task automatic check_addrs(input string name, input logic [ADDR_W-1:0] first, input int n);
    checks++;
    if (cs_addr_q.size() != n) begin
      failures++;
      $display("FAIL %s_cs_count got=%0d want=%0d", name, cs_addr_q.size(), n);
    end
    for (int i = 0; i < n && i < cs_addr_q.size(); i++) begin
      logic [ADDR_W-1:0] exp_a;
      exp_a = first + ADDR_W'(i);
      checks++;
      if (cs_addr_q[i] !== exp_a) begin
        failures++;
        $display("FAIL %s_addr[%0d] got=%h want=%h", name, i, cs_addr_q[i], exp_a);
      end
    end
  endtask

  task automatic test_reset();
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    data_ready = 1'b0;
    repeat (3) tick();
    checks += 6;
    if (busy !== 1'b0)       begin failures++; $display("FAIL rst_busy got=%b want=0", busy); end
    if (done !== 1'b0)       begin failures++; $display("FAIL rst_done got=%b want=0", done); end
    if (flash_cs !== 1'b0)   begin failures++; $display("FAIL rst_cs got=%b want=0", flash_cs); end
    if (flash_address !== '0) begin failures++; $display("FAIL rst_addr got=%h want=0", flash_address); end
    if (data_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b want=0", data_valid); end
    if (data_out !== '0)     begin failures++; $display("FAIL rst_data got=%h want=0", data_out); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit ok;
    int pops0;
    clear_log();
    pops0      = pop_total;
    data_ready = 1'b1;
    do_start(22'h080000, 16'd4);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_start got=%b want=1", busy); end
    wait_done(4 * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done_timeout got=0 want=1"); end
    checks += 2;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy_at_done got=%b want=1", busy); end
    if (data_valid !== 1'b0) begin failures++; $display("FAIL basic_no_bypass got=%b want=0", data_valid); end
    check_addrs("basic", 22'h080000, 4);
    for (int i = 1; i < cs_cyc_q.size(); i++) begin
      checks++;
      if (cs_cyc_q[i] - cs_cyc_q[i-1] != READ_LAT + 1) begin
        failures++;
        $display("FAIL basic_spacing[%0d] got=%0d want=%0d", i, cs_cyc_q[i] - cs_cyc_q[i-1], READ_LAT + 1);
      end
    end
    if (cs_cyc_q.size() == 4) begin
      checks++;
      if (cyc != cs_cyc_q[3] + READ_LAT) begin
        failures++;
        $display("FAIL basic_done_cycle got=%0d want=%0d", cyc, cs_cyc_q[3] + READ_LAT);
      end
    end
    tick();
    checks += 3;
    if (busy !== 1'b0) begin failures++; $display("FAIL basic_busy_after got=%b want=0", busy); end
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b want=0", done); end
    if (data_valid !== 1'b1) begin failures++; $display("FAIL basic_last_visible got=%b want=1", data_valid); end
    repeat (4) tick();
    checks += 2;
    if (pop_total - pops0 != 4) begin failures++; $display("FAIL basic_pops got=%0d want=4", pop_total - pops0); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL basic_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int pops0;
    clear_log();
    pops0      = pop_total;
    data_ready = 1'b0;
    do_start(22'h001000, 16'd12);
    repeat (FIFO_DEPTH * (READ_LAT + 1) + 60) tick();
    checks += 3;
    if (cs_addr_q.size() != FIFO_DEPTH) begin
      failures++; $display("FAIL bp_cs_held got=%0d want=%0d", cs_addr_q.size(), FIFO_DEPTH);
    end
    if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b want=1", busy); end
    if (data_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b want=1", data_valid); end
    data_ready = 1'b1;
    wait_done(4 * (READ_LAT + 1) + 40, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_done_timeout got=0 want=1"); end
    repeat (4) tick();
    check_addrs("bp", 22'h001000, 12);
    checks += 2;
    if (pop_total - pops0 != 12) begin failures++; $display("FAIL bp_pops got=%0d want=12", pop_total - pops0); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_wrap();
    bit ok;
    clear_log();
    data_ready = 1'b1;
    do_start(22'h3FFFFE, 16'd4);
    wait_done(4 * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wrap_done_timeout got=0 want=1"); end
    repeat (4) tick();
    check_addrs("wrap", 22'h3FFFFE, 4);
  endtask

  task automatic test_zero_and_busy_start();
    bit ok;
    int cs0, pops0;
    clear_log();
    cs0        = cs_total;
    data_ready = 1'b1;
    do_start(22'h000500, 16'd0);
    checks += 2;
    if (done !== 1'b1) begin failures++; $display("FAIL zero_done got=%b want=1", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy got=%b want=0", busy); end
    tick();
    checks += 2;
    if (done !== 1'b0) begin failures++; $display("FAIL zero_done_pulse got=%b want=0", done); end
    if (busy !== 1'b0) begin failures++; $display("FAIL zero_busy_after got=%b want=0", busy); end
    repeat (10) tick();
    checks++;
    if (cs_total != cs0) begin failures++; $display("FAIL zero_no_cs got=%0d want=%0d", cs_total - cs0, 0); end

    pops0 = pop_total;
    do_start(22'h002000, 16'd4);
    repeat (READ_LAT + 10) tick();
    do_start(22'h003000, 16'd7);
    wait_done(4 * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ign_done_timeout got=0 want=1"); end
    repeat (60) tick();
    check_addrs("ign", 22'h002000, 4);
    checks += 2;
    if (busy !== 1'b0) begin failures++; $display("FAIL ign_busy got=%b want=0", busy); end
    if (pop_total - pops0 != 4) begin failures++; $display("FAIL ign_pops got=%0d want=4", pop_total - pops0); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cs0, pops0;
    clear_log();
    cs0        = cs_total;
    data_ready = 1'b0;
    do_start(22'h005000, 16'd6);
    wait_cs(cs0 + 3, 3 * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_cs_timeout got=0 want=1"); end
    repeat (10) tick();
    checks++;
    if (data_valid !== 1'b1) begin failures++; $display("FAIL rmid_queued got=%b want=1", data_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks += 3;
    if (data_valid !== 1'b0) begin failures++; $display("FAIL rmid_flush got=%b want=0", data_valid); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy got=%b want=0", busy); end
    if (flash_cs !== 1'b0) begin failures++; $display("FAIL rmid_cs got=%b want=0", flash_cs); end
    cs0 = cs_total;
    repeat (READ_LAT + 20) tick();
    checks++;
    if (cs_total != cs0) begin failures++; $display("FAIL rmid_no_cs got=%0d want=0", cs_total - cs0); end

    clear_log();
    pops0      = pop_total;
    data_ready = 1'b1;
    do_start(22'h006000, 16'd2);
    wait_done(2 * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rmid_restart_timeout got=0 want=1"); end
    repeat (4) tick();
    check_addrs("rmid", 22'h006000, 2);
    checks++;
    if (pop_total - pops0 != 2) begin failures++; $display("FAIL rmid_pops got=%0d want=2", pop_total - pops0); end
  endtask

  task automatic test_full_simul();
    bit ok;
    int cs0, pops0, c9;
    clear_log();
    cs0        = cs_total;
    pops0      = pop_total;
    data_ready = 1'b0;
    do_start(22'h007000, 16'd10);
    wait_cs(cs0 + FIFO_DEPTH, FIFO_DEPTH * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_fill_timeout got=0 want=1"); end
    repeat (READ_LAT + 5) tick();
    checks++;
    if (flash_cs !== 1'b0 || busy !== 1'b1) begin
      failures++; $display("FAIL full_hold got=cs%b/busy%b want=cs0/busy1", flash_cs, busy);
    end
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    wait_cs(cs0 + FIFO_DEPTH + 1, 10, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_reissue_timeout got=0 want=1"); end
    c9 = cs_cyc_q.size() > FIFO_DEPTH ? cs_cyc_q[FIFO_DEPTH] : cyc;
    while (cyc < c9 + READ_LAT) tick();
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    checks++;
    if (flash_cs !== 1'b1) begin failures++; $display("FAIL full_push_pop_cs got=%b want=1", flash_cs); end
    data_ready = 1'b1;
    wait_done(2 * (READ_LAT + 1) + 20, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_done_timeout got=0 want=1"); end
    repeat (FIFO_DEPTH + 4) tick();
    check_addrs("full", 22'h007000, 10);
    checks += 2;
    if (pop_total - pops0 != 10) begin failures++; $display("FAIL full_pops got=%0d want=10", pop_total - pops0); end
    if (exp_q.size() != 0) begin failures++; $display("FAIL full_leftover got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    start_addr = '0;
    word_count = '0;
    data_ready = 1'b0;
    flash_dout = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_wrap();
    test_zero_and_busy_start();
    test_reset_mid();
    test_full_simul();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cyc=%0d bench did not finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
